// File: rtl/prefetcher_pkg.sv
// Shared types and helpers for the stride-prefetcher issue path.
// Address width, controller state encoding and the inclusive window test.
package prefetcher_pkg;

   localparam int ADDR_BITS = 64;

   typedef logic [ADDR_BITS-1:0] addr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_FULL
   } pf_state_e;

   // Unsigned, inclusive at both ends.
   function automatic logic in_window(input addr_t a, input addr_t lo, input addr_t hi);
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/prefetch_issue_ctrl_if.sv
// Prefetch request/response port between the issue controller and the
// memory-request arbiter.
interface prefetch_issue_ctrl_if #(
   parameter int ADDR_BITS = prefetcher_pkg::ADDR_BITS
);

   logic                 pfReqValid;
   logic [ADDR_BITS-1:0] pfReqAddr;
   logic                 pfReqReady;
   logic                 pfRespValid;

   modport master (
      output pfReqValid,
      output pfReqAddr,
      input  pfReqReady,
      input  pfRespValid
   );

   modport slave (
      input  pfReqValid,
      input  pfReqAddr,
      output pfReqReady,
      output pfRespValid
   );

endinterface

// File: rtl/pf_addr_gen.sv
// Combinational next-address step: base + stride, wrap detection, and the
// live [bar, limit] window test.
module pf_addr_gen #(
   parameter int ADDR_BITS = 64
) (
   input  logic [ADDR_BITS-1:0] i_base,
   input  logic [ADDR_BITS-1:0] i_stride,
   input  logic [ADDR_BITS-1:0] i_bar,
   input  logic [ADDR_BITS-1:0] i_limit,
   output logic [ADDR_BITS-1:0] o_next,
   output logic                 o_valid
);
   import prefetcher_pkg::*;

   logic [ADDR_BITS:0] w_sum;
   logic               w_wrap;
   logic               w_in_win;

   assign w_sum  = {1'b0, i_base} + {1'b0, i_stride};
   assign o_next = w_sum[ADDR_BITS-1:0];

   // A negative stride must carry out (no borrow); a positive one must not.
   assign w_wrap   = i_stride[ADDR_BITS-1] ? ~w_sum[ADDR_BITS] : w_sum[ADDR_BITS];
   assign w_in_win = in_window(addr_t'(o_next), addr_t'(i_bar), addr_t'(i_limit));
   assign o_valid  = !w_wrap && w_in_win;

endmodule

// File: rtl/prefetch_issue_ctrl.sv
// Prefetch issue sequencer: turns a confirmed stride plus demand hits into a
// windowed burst of prefetch requests while capping in-flight requests.
module prefetch_issue_ctrl #(
   parameter int ADDR_BITS = prefetcher_pkg::ADDR_BITS,
   parameter int CNT_BITS  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 strideValid,
   input  logic [ADDR_BITS-1:0] stride,
   input  logic                 demandValid,
   input  logic [ADDR_BITS-1:0] demandAddr,
   input  logic                 flush,
   input  logic [CNT_BITS-1:0]  maxOutstandingReqs,
   input  logic [ADDR_BITS-1:0] bar,
   input  logic [ADDR_BITS-1:0] limit,
   prefetch_issue_ctrl_if.master pf,
   output logic [CNT_BITS-1:0]  outstandingCnt,
   output logic                 busy
);
   import prefetcher_pkg::*;

   pf_state_e            r_state;
   logic                 r_pf_valid;
   logic [ADDR_BITS-1:0] r_pf_addr;
   logic [CNT_BITS-1:0]  r_out_cnt;
   logic [CNT_BITS-1:0]  r_credits;
   logic [ADDR_BITS-1:0] r_locked_stride;
   logic                 r_stream_valid;
   logic [ADDR_BITS-1:0] r_next_addr;
   logic                 r_abort;

   logic [ADDR_BITS-1:0] w_trig_next;
   logic                 w_trig_ok;
   logic [ADDR_BITS-1:0] w_step_next;
   logic                 w_step_ok;
   logic                 w_trig;
   logic                 w_same_stride;
   logic                 w_new_stream;
   logic                 w_hs;
   logic                 w_resp_eff;
   logic                 w_abort;
   logic                 w_cand_ok;
   logic [ADDR_BITS-1:0] w_cand;
   logic [CNT_BITS:0]    w_out_after;
   logic [CNT_BITS:0]    w_max_ext;
   logic [CNT_BITS-1:0]  w_cred_up;
   logic [CNT_BITS-1:0]  w_cred_after;

   pf_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_trig_gen (
      .i_base   (demandAddr),
      .i_stride (stride),
      .i_bar    (bar),
      .i_limit  (limit),
      .o_next   (w_trig_next),
      .o_valid  (w_trig_ok)
   );

   pf_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_step_gen (
      .i_base   (r_pf_addr),
      .i_stride (r_locked_stride),
      .i_bar    (bar),
      .i_limit  (limit),
      .o_next   (w_step_next),
      .o_valid  (w_step_ok)
   );

   assign w_trig        = demandValid && strideValid && (stride != '0);
   assign w_same_stride = (stride == r_locked_stride);
   assign w_new_stream  = !r_stream_valid || !w_same_stride;
   assign w_hs          = r_pf_valid && pf.pfReqReady;
   assign w_resp_eff    = pf.pfRespValid && (r_out_cnt != '0);
   assign w_abort       = r_abort || (w_trig && !w_same_stride);

   // Continuations re-test the saved address against the live window.
   assign w_cand    = w_new_stream ? w_trig_next : r_next_addr;
   assign w_cand_ok = (maxOutstandingReqs != '0) &&
                      (w_new_stream ? w_trig_ok
                                    : in_window(addr_t'(r_next_addr), addr_t'(bar), addr_t'(limit)));

   assign w_max_ext   = {1'b0, maxOutstandingReqs};
   assign w_out_after = ({1'b0, r_out_cnt} + (CNT_BITS+1)'(w_hs)) - (CNT_BITS+1)'(w_resp_eff);

   assign w_cred_up    = (w_trig && w_same_stride && (r_credits < maxOutstandingReqs))
                         ? r_credits + CNT_BITS'(1) : r_credits;
   assign w_cred_after = (w_hs && (w_cred_up != '0)) ? w_cred_up - CNT_BITS'(1) : w_cred_up;

   // NOTE: all state lives in one clocked block with non-blocking updates, so
   // every branch reads pre-edge values and en low freezes everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_pf_valid      <= 1'b0;
         r_pf_addr       <= '0;
         r_out_cnt       <= '0;
         r_credits       <= '0;
         r_locked_stride <= '0;
         r_stream_valid  <= 1'b0;
         r_next_addr     <= '0;
         r_abort         <= 1'b0;
      end else if (en) begin
         r_out_cnt <= w_out_after[CNT_BITS-1:0];
         if (flush) begin
            r_state        <= S_IDLE;
            r_pf_valid     <= 1'b0;
            r_credits      <= '0;
            r_stream_valid <= 1'b0;
            r_abort        <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_abort <= 1'b0;
                  if (w_trig) begin
                     if (w_new_stream) r_locked_stride <= stride;
                     if (w_cand_ok) begin
                        r_state    <= S_ISSUE;
                        r_pf_addr  <= w_cand;
                        r_pf_valid <= (r_out_cnt < maxOutstandingReqs);
                        r_credits  <= w_new_stream ? maxOutstandingReqs : CNT_BITS'(1);
                     end else begin
                        r_stream_valid <= 1'b0;
                     end
                  end
               end

               S_ISSUE: begin
                  r_credits <= w_cred_after;
                  if (w_trig && !w_same_stride) r_abort <= 1'b1;
                  if (w_hs) begin
                     r_pf_addr <= w_step_next;
                     if (!w_step_ok || w_abort) begin
                        r_state        <= S_IDLE;
                        r_pf_valid     <= 1'b0;
                        r_stream_valid <= 1'b0;
                     end else if (w_cred_after == '0) begin
                        r_state        <= S_IDLE;
                        r_pf_valid     <= 1'b0;
                        r_stream_valid <= 1'b1;
                        r_next_addr    <= w_step_next;
                     end else if (w_out_after >= w_max_ext) begin
                        r_state    <= S_FULL;
                        r_pf_valid <= 1'b0;
                     end
                  end else if (!r_pf_valid) begin
                     // No request pending: either abort, (re)issue, or wait for room.
                     if (w_abort) begin
                        r_state        <= S_IDLE;
                        r_stream_valid <= 1'b0;
                     end else if (w_out_after < w_max_ext) begin
                        r_pf_valid <= 1'b1;
                     end else begin
                        r_state <= S_FULL;
                     end
                  end
               end

               S_FULL: begin
                  r_credits <= w_cred_after;
                  if (w_abort) begin
                     r_state        <= S_IDLE;
                     r_stream_valid <= 1'b0;
                  end else if (w_resp_eff) begin
                     r_state    <= S_ISSUE;
                     r_pf_valid <= (w_out_after < w_max_ext);
                  end
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign pf.pfReqValid  = r_pf_valid;
   assign pf.pfReqAddr   = r_pf_addr;
   assign outstandingCnt = r_out_cnt;
   assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_prefetch_issue_ctrl.sv
// Directed bench for prefetch_issue_ctrl: bursts, cap/continuation, window
// limits, flush, backpressure, stride change and async reset.
module tb_prefetch_issue_ctrl;

   localparam int AW = 64;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          strideValid;
   logic [AW-1:0] stride;
   logic          demandValid;
   logic [AW-1:0] demandAddr;
   logic          flush;
   logic [CW-1:0] maxOutstandingReqs;
   logic [AW-1:0] bar;
   logic [AW-1:0] limit;
   logic [CW-1:0] outstandingCnt;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   prefetch_issue_ctrl_if #(.ADDR_BITS(AW)) pf_if ();

   prefetch_issue_ctrl #(.ADDR_BITS(AW), .CNT_BITS(CW)) dut (
      .clk                (clk),
      .reset              (reset),
      .en                 (en),
      .strideValid        (strideValid),
      .stride             (stride),
      .demandValid        (demandValid),
      .demandAddr         (demandAddr),
      .flush              (flush),
      .maxOutstandingReqs (maxOutstandingReqs),
      .bar                (bar),
      .limit              (limit),
      .pf                 (pf_if.master),
      .outstandingCnt     (outstandingCnt),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic trigger(input logic [AW-1:0] addr);
      demandAddr  = addr;
      demandValid = 1'b1;
      tick();
      demandValid = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      en                 = 1'b1;
      strideValid        = 1'b1;
      stride             = 64'h40;
      demandValid        = 1'b0;
      demandAddr         = '0;
      flush              = 1'b0;
      maxOutstandingReqs = 5'd4;
      bar                = '0;
      limit              = 64'hFFFF;
      pf_if.pfReqReady   = 1'b1;
      pf_if.pfRespValid  = 1'b0;

      tick();
      tick();
      check("rst_valid", pf_if.pfReqValid, 0);
      check("rst_addr",  pf_if.pfReqAddr, 0);
      check("rst_cnt",   outstandingCnt, 0);
      check("rst_busy",  busy, 0);
      reset = 1'b0;
      tick();
      check("idle_no_trig", pf_if.pfReqValid, 0);

      // Full burst of four back-to-back requests
      trigger(64'h1000);
      check("burst0_valid", pf_if.pfReqValid, 1);
      check("burst0_addr",  pf_if.pfReqAddr, 64'h1040);
      check("burst0_busy",  busy, 1);
      tick();
      check("burst1_addr", pf_if.pfReqAddr, 64'h1080);
      check("burst1_cnt",  outstandingCnt, 1);
      tick();
      check("burst2_addr", pf_if.pfReqAddr, 64'h10C0);
      check("burst2_cnt",  outstandingCnt, 2);
      tick();
      check("burst3_addr", pf_if.pfReqAddr, 64'h1100);
      check("burst3_cnt",  outstandingCnt, 3);
      tick();
      check("burst_end_valid", pf_if.pfReqValid, 0);
      check("burst_end_cnt",   outstandingCnt, 4);
      check("burst_end_busy",  busy, 0);

      // Continuation blocked by the cap, released by one response
      trigger(64'h1040);
      check("cont_issue_valid", pf_if.pfReqValid, 0);
      check("cont_issue_busy",  busy, 1);
      tick();
      check("cont_full_valid", pf_if.pfReqValid, 0);
      check("cont_full_cnt",   outstandingCnt, 4);
      check("cont_full_busy",  busy, 1);
      pf_if.pfRespValid = 1'b1;
      tick();
      pf_if.pfRespValid = 1'b0;
      check("cont_resp_valid", pf_if.pfReqValid, 1);
      check("cont_resp_addr",  pf_if.pfReqAddr, 64'h1140);
      check("cont_resp_cnt",   outstandingCnt, 3);

      // en low freezes a pending request and ignores ready/resp
      en = 1'b0;
      pf_if.pfRespValid = 1'b1;
      tick();
      tick();
      check("en_hold_valid", pf_if.pfReqValid, 1);
      check("en_hold_addr",  pf_if.pfReqAddr, 64'h1140);
      check("en_hold_cnt",   outstandingCnt, 3);
      en = 1'b1;
      pf_if.pfRespValid = 1'b0;
      tick();
      check("cont_done_cnt",   outstandingCnt, 4);
      check("cont_done_valid", pf_if.pfReqValid, 0);
      check("cont_done_busy",  busy, 0);

      // Asynchronous reset in the middle of a burst
      pulse_reset();
      trigger(64'h2000);
      check("rb0_addr", pf_if.pfReqAddr, 64'h2040);
      tick();
      check("rb1_addr", pf_if.pfReqAddr, 64'h2080);
      check("rb1_cnt",  outstandingCnt, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", pf_if.pfReqValid, 0);
      check("async_rst_addr",  pf_if.pfReqAddr, 0);
      check("async_rst_cnt",   outstandingCnt, 0);
      check("async_rst_busy",  busy, 0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_valid", pf_if.pfReqValid, 0);
      check("post_rst_busy",  busy, 0);

      // Window top cuts the burst short
      limit = 64'h10A0;
      trigger(64'h1000);
      check("win0_addr", pf_if.pfReqAddr, 64'h1040);
      tick();
      check("win1_addr", pf_if.pfReqAddr, 64'h1080);
      check("win1_valid", pf_if.pfReqValid, 1);
      tick();
      check("win_end_valid", pf_if.pfReqValid, 0);
      check("win_end_cnt",   outstandingCnt, 2);
      check("win_end_busy",  busy, 0);
      trigger(64'h1000);
      check("win_restart_addr", pf_if.pfReqAddr, 64'h1040);
      check("win_restart_valid", pf_if.pfReqValid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_hs_valid", pf_if.pfReqValid, 0);
      check("flush_hs_cnt",   outstandingCnt, 3);
      check("flush_hs_busy",  busy, 0);

      // Negative stride reaching bar, then borrow
      pulse_reset();
      limit  = 64'hFFFF;
      stride = 64'hFFFF_FFFF_FFFF_FFC0;
      trigger(64'h40);
      check("neg_valid", pf_if.pfReqValid, 1);
      check("neg_addr",  pf_if.pfReqAddr, 64'h0);
      tick();
      check("neg_end_valid", pf_if.pfReqValid, 0);
      check("neg_end_cnt",   outstandingCnt, 1);
      check("neg_end_busy",  busy, 0);

      // Response with nothing in flight is ignored
      pulse_reset();
      stride = 64'h40;
      pf_if.pfRespValid = 1'b1;
      tick();
      pf_if.pfRespValid = 1'b0;
      check("resp_at_zero", outstandingCnt, 0);

      // Backpressure holds the address; flush drops valid
      pf_if.pfReqReady = 1'b0;
      trigger(64'h1000);
      check("bp0_addr", pf_if.pfReqAddr, 64'h1040);
      pf_if.pfReqReady = 1'b1;
      tick();
      check("bp1_addr", pf_if.pfReqAddr, 64'h1080);
      check("bp1_cnt",  outstandingCnt, 1);
      pf_if.pfReqReady = 1'b0;
      tick();
      tick();
      check("bp_hold_valid", pf_if.pfReqValid, 1);
      check("bp_hold_addr",  pf_if.pfReqAddr, 64'h1080);
      check("bp_hold_cnt",   outstandingCnt, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("bp_flush_valid", pf_if.pfReqValid, 0);
      check("bp_flush_cnt",   outstandingCnt, 1);
      check("bp_flush_busy",  busy, 0);

      // Handshake and response in the same cycle
      trigger(64'h3000);
      check("hsr0_addr", pf_if.pfReqAddr, 64'h3040);
      pf_if.pfReqReady  = 1'b1;
      pf_if.pfRespValid = 1'b1;
      tick();
      pf_if.pfRespValid = 1'b0;
      pf_if.pfReqReady  = 1'b0;
      check("hsr_cnt",  outstandingCnt, 1);
      check("hsr_addr", pf_if.pfReqAddr, 64'h3080);

      // Stride change mid-burst
      pulse_reset();
      trigger(64'h1000);
      check("sc0_addr", pf_if.pfReqAddr, 64'h1040);
      stride = 64'h80;
      trigger(64'h1400);
      check("sc_hold_valid", pf_if.pfReqValid, 1);
      check("sc_hold_addr",  pf_if.pfReqAddr, 64'h1040);
      check("sc_hold_busy",  busy, 1);
      pf_if.pfReqReady = 1'b1;
      tick();
      check("sc_end_valid", pf_if.pfReqValid, 0);
      check("sc_end_cnt",   outstandingCnt, 1);
      check("sc_end_busy",  busy, 0);
      trigger(64'h5000);
      check("sc_new_valid", pf_if.pfReqValid, 1);
      check("sc_new_addr",  pf_if.pfReqAddr, 64'h5080);

      // Zero depth never issues
      pulse_reset();
      maxOutstandingReqs = 5'd0;
      trigger(64'h1000);
      check("max0_valid", pf_if.pfReqValid, 0);
      check("max0_busy",  busy, 0);
      tick();
      check("max0_valid2", pf_if.pfReqValid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
